// File: rtl/bp_pkg.sv
// bp_pkg: shared types, widths and counter helper for the BHT port scheduler
// Widths: BP_IDX_W table index bits (from BHT_IDX_WIDTH), BP_CTR_W counter bits
`ifndef BHT_IDX_WIDTH
`define BHT_IDX_WIDTH 4
`endif
package bp_pkg;
    localparam int BP_IDX_W = `BHT_IDX_WIDTH;
    localparam int BP_CTR_W = 2;
    typedef enum logic {INIT, RUN} sched_state_e;
    typedef struct packed {
        logic [BP_IDX_W-1:0] idx;
        logic                taken;
        logic [BP_CTR_W-1:0] ctr;
    } upd_entry_t;
    function automatic logic [BP_CTR_W-1:0] ctr_sat_update(input logic [BP_CTR_W-1:0] ctr, input logic taken);
        return taken ? (&ctr ? ctr : ctr + BP_CTR_W'(1)) : (|ctr ? ctr - BP_CTR_W'(1) : ctr);
    endfunction
endpackage

// File: rtl/bp_sync_fifo.sv
// bp_sync_fifo: synchronous FIFO of arbitrary entry type, power-of-two depth
// Ports: clk_i/rst_i clock and sync reset, push_i/din_i write side, pop_i/dout_o
// read side (dout_o is the head entry), full_o/empty_o/count_o occupancy
module bp_sync_fifo #(
    parameter type T = logic,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  T                         din_i,
    input  logic                     pop_i,
    output T                         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    T mem_q [DEPTH];
    T mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0] cnt_q, cnt_d;
    logic do_push, do_pop;
    always_comb begin
        full_o = cnt_q == (AW+1)'(DEPTH);
        empty_o = cnt_q == '0;
        count_o = cnt_q;
        dout_o = mem_q[rd_q];
        do_push = push_i & ~full_o;
        do_pop = pop_i & ~empty_o;
        mem_d = mem_q;
        if (do_push) mem_d[wr_q] = din_i;
        wr_d = do_push ? wr_q + AW'(1) : wr_q;
        rd_d = do_pop ? rd_q + AW'(1) : rd_q;
        cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/bht_port_sched.sv
// bht_port_sched: shares one sync-read BHT port between lookups and buffered updates, clears the table after reset
// Ports: clk_i/rst_i clock and sync active-high reset; lookup_* fetch request
// (ready is combinational); pred_* prediction one cycle after an accepted lookup;
// upd_* commit-side update push into the FIFO; tbl_* table RAM port;
// init_done_o high once the clearing sweep is complete
module bht_port_sched
    import bp_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 8,
    parameter logic [BP_CTR_W-1:0] INIT_CTR = '0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                lookup_valid_i,
    input  logic [BP_IDX_W-1:0] lookup_idx_i,
    output logic                lookup_ready_o,
    output logic                pred_valid_o,
    output logic                pred_taken_o,
    output logic [BP_CTR_W-1:0] pred_ctr_o,
    input  logic                upd_valid_i,
    input  logic [BP_IDX_W-1:0] upd_idx_i,
    input  logic                upd_taken_i,
    input  logic [BP_CTR_W-1:0] upd_ctr_i,
    output logic                upd_ready_o,
    output logic                tbl_en_o,
    output logic                tbl_we_o,
    output logic [BP_IDX_W-1:0] tbl_idx_o,
    output logic [BP_CTR_W-1:0] tbl_wdata_o,
    input  logic [BP_CTR_W-1:0] tbl_rdata_i,
    output logic                init_done_o
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    sched_state_e state_q, state_d;
    logic [BP_IDX_W-1:0] sweep_q, sweep_d;
    logic [SW-1:0] starve_q, starve_d;
    logic init_done_q, init_done_d, pred_valid_q, pred_valid_d;
    logic run, init, force_upd, rd, pop, push;
    logic fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_cnt;
    upd_entry_t push_e, head;
    assign push_e = '{idx: upd_idx_i, taken: upd_taken_i, ctr: upd_ctr_i};
    bp_sync_fifo #(.T(upd_entry_t), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .din_i   (push_e),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );
    // every output is forced low while reset is held, even mid-operation
    always_comb begin
        run = (state_q == RUN) & ~rst_i;
        init = (state_q == INIT) & ~rst_i;
        force_upd = run & (fifo_full | (fifo_cnt != '0 && starve_q == SW'(STARVE_MAX)));
        rd = run & ~force_upd & lookup_valid_i;
        pop = run & ~fifo_empty & (force_upd | ~lookup_valid_i);
        lookup_ready_o = run & ~force_upd;
        upd_ready_o = run & ~fifo_full;
        push = upd_valid_i & upd_ready_o;
        tbl_en_o = init | rd | pop;
        tbl_we_o = init | pop;
        tbl_idx_o = init ? sweep_q : pop ? head.idx : rd ? lookup_idx_i : '0;
        tbl_wdata_o = init ? INIT_CTR : pop ? ctr_sat_update(head.ctr, head.taken) : '0;
        init_done_o = init_done_q & ~rst_i;
        pred_valid_o = pred_valid_q & ~rst_i;
        pred_ctr_o = pred_valid_o ? tbl_rdata_i : '0;
        pred_taken_o = pred_ctr_o[BP_CTR_W-1];
        state_d = (init && &sweep_q) ? RUN : state_q;
        sweep_d = init ? sweep_q + BP_IDX_W'(1) : sweep_q;
        init_done_d = init_done_q | (init && &sweep_q);
        pred_valid_d = rd;
        starve_d = (fifo_empty | pop) ? '0 : starve_q == SW'(STARVE_MAX) ? starve_q : starve_q + SW'(1);
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= INIT;
            sweep_q <= '0;
            starve_q <= '0;
            init_done_q <= 1'b0;
            pred_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            starve_q <= starve_d;
            init_done_q <= init_done_d;
            pred_valid_q <= pred_valid_d;
        end
    end
endmodule

// File: tb/tb_bht_port_sched.sv
// tb_bht_port_sched: directed, table-driven check of bht_port_sched against a 16-entry sync-read table
module tb_bht_port_sched;
    logic clk = 1'b0, rst = 1'b1;
    logic lookup_valid, lookup_ready, pred_valid, pred_taken, upd_valid, upd_taken, upd_ready;
    logic tbl_en, tbl_we, init_done;
    logic [3:0] lookup_idx, upd_idx, tbl_idx;
    logic [1:0] pred_ctr, upd_ctr, tbl_wdata, tbl_rdata;
    logic [1:0] ram [16];
    int total = 0, bad = 0;
    typedef struct { int lv, li, uv, ui, ut, uc; logic [14:0] e; } vec_t;
    vec_t tv[$];
    always #5 clk = ~clk;
    bht_port_sched dut (
        .clk_i(clk), .rst_i(rst),
        .lookup_valid_i(lookup_valid), .lookup_idx_i(lookup_idx), .lookup_ready_o(lookup_ready),
        .pred_valid_o(pred_valid), .pred_taken_o(pred_taken), .pred_ctr_o(pred_ctr),
        .upd_valid_i(upd_valid), .upd_idx_i(upd_idx), .upd_taken_i(upd_taken), .upd_ctr_i(upd_ctr),
        .upd_ready_o(upd_ready), .tbl_en_o(tbl_en), .tbl_we_o(tbl_we), .tbl_idx_o(tbl_idx),
        .tbl_wdata_o(tbl_wdata), .tbl_rdata_i(tbl_rdata), .init_done_o(init_done)
    );
    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 2'd3;
        tbl_rdata = 2'd0;
    end
    always @(posedge clk)
        if (tbl_en) begin
            if (tbl_we) ram[tbl_idx] <= tbl_wdata;
            else tbl_rdata <= ram[tbl_idx];
        end
    function automatic logic [14:0] mk(int en, int we, int idx, int wd, int lr, int ur, int pv, int pt, int pc, int dn);
        return {1'(en), 1'(we), 4'(idx), 2'(wd), 1'(lr), 1'(ur), 1'(pv), 1'(pt), 2'(pc), 1'(dn)};
    endfunction
    function automatic logic [14:0] obs();
        return {tbl_en, tbl_we, tbl_idx, tbl_wdata, lookup_ready, upd_ready, pred_valid, pred_taken, pred_ctr, init_done};
    endfunction
    task automatic chk(input string nm, input logic [14:0] e);
        logic [14:0] a;
        a = obs();
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %b want %b (en we idx wd lrdy urdy pv pt pctr done)", nm, a, e);
        end
    endtask
    task automatic cyc(input string nm, input int lv, li, uv, ui, ut, uc, input logic [14:0] e);
        lookup_valid = 1'(lv);
        lookup_idx = 4'(li);
        upd_valid = 1'(uv);
        upd_idx = 4'(ui);
        upd_taken = 1'(ut);
        upd_ctr = 2'(uc);
        #3;
        chk(nm, e);
        @(posedge clk);
        #1;
    endtask
    task automatic add(input int lv, li, uv, ui, ut, uc, input logic [14:0] e);
        tv.push_back('{lv, li, uv, ui, ut, uc, e});
    endtask
    initial begin
        logic [14:0] z;
        z = mk(0,0,0,0,0,0,0,0,0,0);
        lookup_valid = 0; lookup_idx = 0; upd_valid = 0; upd_idx = 0; upd_taken = 0; upd_ctr = 0;
        add(1,5,0,0,0,0, mk(1,0,5,0,1,1,0,0,0,1));
        add(0,0,0,0,0,0, mk(0,0,0,0,1,1,1,0,0,1));
        add(0,0,1,3,1,1, mk(0,0,0,0,1,1,0,0,0,1));
        add(0,0,0,0,0,0, mk(1,1,3,2,1,1,0,0,0,1));
        add(1,3,0,0,0,0, mk(1,0,3,0,1,1,0,0,0,1));
        add(0,0,0,0,0,0, mk(0,0,0,0,1,1,1,1,2,1));
        add(0,0,1,7,1,3, mk(0,0,0,0,1,1,0,0,0,1));
        add(0,0,1,8,0,0, mk(1,1,7,3,1,1,0,0,0,1));
        add(0,0,0,0,0,0, mk(1,1,8,0,1,1,0,0,0,1));
        add(0,0,1,9,0,2, mk(0,0,0,0,1,1,0,0,0,1));
        add(1,9,0,0,0,0, mk(1,0,9,0,1,1,0,0,0,1));
        add(0,0,0,0,0,0, mk(1,1,9,1,1,1,1,0,0,1));
        add(1,9,0,0,0,0, mk(1,0,9,0,1,1,0,0,0,1));
        add(0,0,0,0,0,0, mk(0,0,0,0,1,1,1,0,1,1));
        repeat (2) @(posedge clk);
        #1;
        cyc("reset", 1,5,1,3,1,1, z);
        rst = 0;
        for (int i = 0; i < 16; i++) cyc("init_sweep", 1,i,1,0,1,1, mk(1,1,i,0,0,0,0,0,0,0));
        foreach (tv[i]) cyc($sformatf("vec%0d", i), tv[i].lv, tv[i].li, tv[i].uv, tv[i].ui, tv[i].ut, tv[i].uc, tv[i].e);
        cyc("starve_push", 1,1,1,4,1,0, mk(1,0,1,0,1,1,0,0,0,1));
        for (int i = 0; i < 8; i++) cyc($sformatf("starve_wait%0d", i), 1,1,0,0,0,0, mk(1,0,1,0,1,1,1,0,0,1));
        cyc("starve_force", 1,1,0,0,0,0, mk(1,1,4,1,0,1,1,0,0,1));
        cyc("starve_after", 1,1,0,0,0,0, mk(1,0,1,0,1,1,0,0,0,1));
        cyc("starve_idle", 0,0,0,0,0,0, mk(0,0,0,0,1,1,1,0,0,1));
        cyc("fill0", 1,2,1,10,1,2, mk(1,0,2,0,1,1,0,0,0,1));
        cyc("fill1", 1,2,1,11,0,3, mk(1,0,2,0,1,1,1,0,0,1));
        cyc("fill2", 1,2,1,12,0,1, mk(1,0,2,0,1,1,1,0,0,1));
        cyc("fill3", 1,2,1,13,1,0, mk(1,0,2,0,1,1,1,0,0,1));
        cyc("full_force", 1,2,1,14,1,1, mk(1,1,10,3,0,0,1,0,0,1));
        cyc("drain1", 0,0,0,0,0,0, mk(1,1,11,2,1,1,0,0,0,1));
        cyc("drain2", 0,0,0,0,0,0, mk(1,1,12,0,1,1,0,0,0,1));
        cyc("drain3", 0,0,0,0,0,0, mk(1,1,13,1,1,1,0,0,0,1));
        cyc("drain_empty", 0,0,0,0,0,0, mk(0,0,0,0,1,1,0,0,0,1));
        cyc("pre_rst", 1,2,1,5,1,1, mk(1,0,2,0,1,1,0,0,0,1));
        rst = 1;
        cyc("rst_run", 1,2,1,6,1,1, z);
        rst = 0;
        for (int i = 0; i < 7; i++) cyc("sweep_a", 0,0,0,0,0,0, mk(1,1,i,0,0,0,0,0,0,0));
        rst = 1;
        cyc("rst_mid", 0,0,0,0,0,0, z);
        rst = 0;
        for (int i = 0; i < 16; i++) cyc("sweep_b", 0,0,0,0,0,0, mk(1,1,i,0,0,0,0,0,0,0));
        cyc("post_sweep", 0,0,0,0,0,0, mk(0,0,0,0,1,1,0,0,0,1));
        cyc("post_lookup", 1,3,0,0,0,0, mk(1,0,3,0,1,1,0,0,0,1));
        cyc("post_pred", 0,0,0,0,0,0, mk(0,0,0,0,1,1,1,0,0,1));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
